// File: rtl/cpuy_pkg.sv
// rtl/cpuy_pkg.sv - shared constants, state type and helpers for the cpuy interrupt logic
package cpuy_pkg;

   // Vector table for the cpuy core
   localparam logic [11:0] VEC_RESET = 12'h000;
   localparam logic [11:0] VEC_EI    = 12'h010;
   localparam logic [11:0] VEC_T0    = 12'h020;
   localparam logic [11:0] VEC_T1    = 12'h030;

   // Source indices; a lower index means a higher priority
   localparam int SRC_EXT = 0;
   localparam int SRC_T0  = 1;
   localparam int SRC_T1  = 2;

   // Interrupt sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_t;

   // active_id: 0 means nothing granted, otherwise source index + 1
   localparam logic [1:0] ACTIVE_NONE = 2'd0;

   function automatic logic [1:0] active_of(input logic [1:0] idx);
      return idx + 2'd1;
   endfunction

   // Vector of a source; the 12-bit add wraps by construction
   function automatic logic [11:0] vec_of(input logic [11:0] base,
                                          input logic [11:0] stride,
                                          input logic [1:0]  idx);
      return base + stride * {10'd0, idx};
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - signal bundle between interrupt sources/CPU and int_ctrl
interface int_ctrl_if #(
   parameter int N_SRC = 3
);
   logic [N_SRC-1:0] src_irq;
   logic             gie;
   logic [N_SRC-1:0] ie;
   logic [N_SRC-1:0] pend_clr;
   logic             int_ack;
   logic             eoi;
   logic             int_req;
   logic [11:0]      int_vector;
   logic [1:0]       active_id;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] src_ack;
   logic             eoi_err;

   // CPU and source side
   modport master (
      output src_irq, gie, ie, pend_clr, int_ack, eoi,
      input  int_req, int_vector, active_id, pending, src_ack, eoi_err
   );

   // Controller side
   modport slave (
      input  src_irq, gie, ie, pend_clr, int_ack, eoi,
      output int_req, int_vector, active_id, pending, src_ack, eoi_err
   );
endinterface

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - fixed-priority encoder, lowest set index wins
module prio_enc #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [W-1:0] idx
);

   // Scan from the top down so the lowest set bit is written last
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - fixed-priority interrupt controller with ack/eoi sequencing
module int_ctrl
   import cpuy_pkg::*;
#(
   parameter int          N_SRC      = 3,
   parameter logic [11:0] VEC_BASE   = VEC_EI,
   parameter logic [11:0] VEC_STRIDE = VEC_T0 - VEC_EI
) (
   input logic       clk,
   input logic       rst,
   int_ctrl_if.slave bus
);

   int_state_t       state_q, state_d;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] src_ack_q, src_ack_d;
   logic [N_SRC-1:0] clr_mask;
   logic [N_SRC-1:0] grant_mask;
   logic [N_SRC-1:0] eligible;
   logic             int_req_q, int_req_d;
   logic [11:0]      vec_q, vec_d;
   logic [1:0]       active_q, active_d;
   logic [1:0]       grant_q, grant_d;
   logic             eoi_err_q, eoi_err_d;
   logic             cand_valid;
   logic [1:0]       cand_idx;

   assign eligible   = pending_q & bus.ie;
   assign grant_mask = N_SRC'(1) << grant_q;

   prio_enc #(
      .N (N_SRC),
      .W (2)
   ) u_prio_enc (
      .req   (eligible),
      .valid (cand_valid),
      .idx   (cand_idx)
   );

   // Next-state, grant and pending update; pending set beats any clear
   always_comb begin
      state_d   = state_q;
      int_req_d = int_req_q;
      vec_d     = vec_q;
      active_d  = active_q;
      grant_d   = grant_q;
      eoi_err_d = eoi_err_q;
      src_ack_d = '0;
      clr_mask  = bus.pend_clr;
      case (state_q)
         ST_IDLE: begin
            if (bus.int_ack || bus.eoi) begin
               eoi_err_d = 1'b1;
            end
            if (bus.gie && cand_valid) begin
               grant_d   = cand_idx;
               vec_d     = vec_of(VEC_BASE, VEC_STRIDE, cand_idx);
               active_d  = active_of(cand_idx);
               int_req_d = 1'b1;
               state_d   = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (bus.int_ack) begin
               int_req_d = 1'b0;
               src_ack_d = grant_mask;
               clr_mask  = bus.pend_clr | grant_mask;
               state_d   = ST_SERVICE;
            end else if (!bus.gie || !bus.ie[grant_q]) begin
               int_req_d = 1'b0;
               active_d  = ACTIVE_NONE;
               state_d   = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (bus.eoi) begin
               active_d = ACTIVE_NONE;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      pending_d = (pending_q & ~clr_mask) | (bus.src_irq & ~irq_q);
   end

   // State and output registers; reset abandons any service in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         irq_q     <= '0;
         pending_q <= '0;
         src_ack_q <= '0;
         int_req_q <= 1'b0;
         vec_q     <= VEC_RESET;
         active_q  <= ACTIVE_NONE;
         grant_q   <= 2'd0;
         eoi_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_q     <= bus.src_irq;
         pending_q <= pending_d;
         src_ack_q <= src_ack_d;
         int_req_q <= int_req_d;
         vec_q     <= vec_d;
         active_q  <= active_d;
         grant_q   <= grant_d;
         eoi_err_q <= eoi_err_d;
      end
   end

   assign bus.int_req    = int_req_q;
   assign bus.int_vector = vec_q;
   assign bus.active_id  = active_q;
   assign bus.pending    = pending_q;
   assign bus.src_ack    = src_ack_q;
   assign bus.eoi_err    = eoi_err_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - scoreboard bench for int_ctrl against a behavioural model
module tb_int_ctrl;
   import cpuy_pkg::*;

   localparam logic [11:0] TB_BASE   = 12'h010;
   localparam logic [11:0] TB_STRIDE = 12'h010;

   typedef struct packed {
      logic        req;
      logic [11:0] vec;
      logic [1:0]  id;
      logic [2:0]  pend;
      logic [2:0]  sack;
      logic        err;
   } snap_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int_ctrl_if #(.N_SRC(3)) bus ();

   int_ctrl #(.N_SRC(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   snap_t exp_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   logic [2:0] cur_irq = 3'b000;
   logic       cur_gie = 1'b1;
   logic [2:0] cur_ie  = 3'b111;

   // Model state: which source is being offered or serviced, and the pending set
   logic [2:0]  m_pend = '0;
   logic [2:0]  m_prev = '0;
   int          m_held = -1;
   bit          m_svc  = 1'b0;
   logic        m_req  = 1'b0;
   logic [11:0] m_vec  = '0;
   logic [1:0]  m_id   = '0;
   logic        m_err  = 1'b0;

   task automatic model_step(input logic r, input logic [2:0] irq, input logic g,
                             input logic [2:0] en, input logic [2:0] clr,
                             input logic ack, input logic e);
      logic [2:0] nxt;
      logic [2:0] sack;
      int         cand;
      snap_t      s;
      sack = '0;
      if (r) begin
         m_pend = '0; m_prev = '0; m_held = -1; m_svc = 1'b0;
         m_req = 1'b0; m_vec = '0; m_id = '0; m_err = 1'b0;
      end else begin
         nxt = m_pend & ~clr;
         if (m_held < 0) begin
            if (ack || e) m_err = 1'b1;
            cand = -1;
            if (g) begin
               for (int i = 2; i >= 0; i--) if (m_pend[i] && en[i]) cand = i;
            end
            if (cand >= 0) begin
               m_held = cand;
               m_req  = 1'b1;
               m_vec  = 12'(TB_BASE + cand * TB_STRIDE);
               m_id   = 2'(cand + 1);
            end
         end else if (!m_svc) begin
            if (ack) begin
               m_req        = 1'b0;
               sack[m_held] = 1'b1;
               nxt[m_held]  = 1'b0;
               m_svc        = 1'b1;
            end else if (!g || !en[m_held]) begin
               m_req  = 1'b0;
               m_id   = '0;
               m_held = -1;
            end
         end else if (e) begin
            m_id   = '0;
            m_held = -1;
            m_svc  = 1'b0;
         end
         m_pend = nxt | (irq & ~m_prev);
         m_prev = irq;
      end
      s = '{req: m_req, vec: m_vec, id: m_id, pend: m_pend, sack: sack, err: m_err};
      exp_q.push_back(s);
   endtask

   task automatic drive(input logic r, input logic [2:0] clr, input logic ack, input logic e);
      @(negedge clk);
      rst          = r;
      bus.src_irq  = cur_irq;
      bus.gie      = cur_gie;
      bus.ie       = cur_ie;
      bus.pend_clr = clr;
      bus.int_ack  = ack;
      bus.eoi      = e;
      model_step(r, cur_irq, cur_gie, cur_ie, clr, ack, e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic pulse_irq(input logic [2:0] bits);
      cur_irq = bits;
      idle(1);
      cur_irq = 3'b000;
   endtask

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
   endtask

   // Monitor: every clock the DUT presents its outputs; compare with the oldest expectation
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("int_req",    12'(bus.int_req),   12'(e.req));
            chk("int_vector", bus.int_vector,     e.vec);
            chk("active_id",  12'(bus.active_id), 12'(e.id));
            chk("pending",    12'(bus.pending),   12'(e.pend));
            chk("src_ack",    12'(bus.src_ack),   12'(e.sack));
            chk("eoi_err",    12'(bus.eoi_err),   12'(e.err));
         end
      end
   end

   initial begin
      bus.src_irq  = '0;
      bus.gie      = 1'b1;
      bus.ie       = 3'b111;
      bus.pend_clr = '0;
      bus.int_ack  = 1'b0;
      bus.eoi      = 1'b0;

      // Reset state
      drive(1'b1, 3'b000, 1'b0, 1'b0);
      drive(1'b1, 3'b000, 1'b0, 1'b0);
      idle(2);

      // Single external event: request, ack, eoi
      pulse_irq(3'b001 << SRC_EXT);
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      idle(3);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(3);

      // Both timers at once: T0 first, then T1 re-requested after eoi
      pulse_irq(3'b110);
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      idle(2);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      idle(2);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(3);

      // Masked source latches but does not request until enabled
      cur_ie = 3'b011;
      pulse_irq(3'b001 << SRC_T1);
      idle(4);
      cur_ie = 3'b111;
      idle(4);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(2);

      // Withdrawal on gie drop, then re-request
      pulse_irq(3'b001 << SRC_T0);
      idle(3);
      cur_gie = 1'b0;
      idle(3);
      cur_gie = 1'b1;
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      idle(1);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(2);

      // Ack in the same cycle as a gie drop wins
      pulse_irq(3'b100);
      idle(3);
      cur_gie = 1'b0;
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      cur_gie = 1'b1;
      idle(2);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(2);

      // No nesting: re-event of source 0 during service, then stray eoi/ack
      pulse_irq(3'b001);
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      idle(1);
      pulse_irq(3'b001);
      idle(4);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(2);
      drive(1'b0, 3'b000, 1'b0, 1'b1);
      idle(3);

      // Reset in the middle of service
      pulse_irq(3'b001);
      idle(3);
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      idle(1);
      drive(1'b1, 3'b000, 1'b0, 1'b0);
      idle(3);

      // Clear and new event together: set wins
      cur_gie = 1'b0;
      cur_irq = 3'b010;
      drive(1'b0, 3'b010, 1'b0, 1'b0);
      cur_irq = 3'b000;
      idle(2);
      drive(1'b0, 3'b010, 1'b0, 1'b0);
      idle(1);
      cur_gie = 1'b1;
      idle(2);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         logic [2:0] clr;
         logic       ack, e, r;
         for (int b = 0; b < 3; b++) if ($urandom_range(99) < 8) cur_irq[b] = ~cur_irq[b];
         if (cur_gie) cur_gie = ($urandom_range(99) >= 3);
         else         cur_gie = ($urandom_range(99) < 30);
         if ($urandom_range(99) < 2) cur_ie = 3'($urandom);
         clr = ($urandom_range(99) < 3) ? 3'($urandom) : 3'b000;
         if (m_held >= 0 && !m_svc) ack = ($urandom_range(99) < 35);
         else                       ack = ($urandom_range(99) < 2);
         if (m_svc) e = ($urandom_range(99) < 25);
         else       e = ($urandom_range(99) < 2);
         r = ($urandom_range(999) < 3);
         drive(r, clr, ack, e);
      end
      cur_irq = 3'b000;
      idle(2);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #3;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
